// File: rtl/cla_pkg.sv
// cla_pkg: shared widths and result-flag type for the carry-lookahead add/subtract path
package cla_pkg;
  localparam int CLA_WIDTH = 32;
  localparam int CLA_STAGES = 4;
  localparam int SLICE_W = CLA_WIDTH / CLA_STAGES;
  typedef struct packed {
    logic under;
    logic ovf;
  } res_flags_t;
endpackage

// File: rtl/sub_slice.sv
// sub_slice: combinational W-bit subtract with borrow-in and borrow-out
module sub_slice
  import cla_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);
  assign {bout, diff} = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
endmodule

// File: rtl/cla32_sub_pipe.sv
// cla32_sub_pipe: pipelined borrow-ripple subtractor recovering B = S - A with range flags
module cla32_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_under,
  output logic             out_ovf
);
  localparam int SW = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic             adv;
  logic             top;
  logic             v    [STAGES];
  logic             bw   [STAGES];
  logic [WIDTH:0]   s    [STAGES];
  logic [WIDTH-1:0] a    [STAGES];
  logic [WIDTH-1:0] d    [STAGES];
  logic [SW-1:0]    diff [STAGES];
  logic             bo   [STAGES];
  res_flags_t       flags;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign top = |(s[L] >> SW);
  assign out_under = flags.under;
  assign out_ovf = flags.ovf;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sub_slice #(.W(SW)) u_sub (
      .x   (SW'(s[k])),
      .y   (SW'(a[k])),
      .bin (bw[k]),
      .diff(diff[k]),
      .bout(bo[k])
    );
  end
  // operands shift right one slice per stage while finished slices shift in from the top
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v[i] <= 1'b0;
        bw[i] <= 1'b0;
        s[i] <= '0;
        a[i] <= '0;
        d[i] <= '0;
      end
      out_valid <= 1'b0;
      out_b <= '0;
      flags <= '0;
    end else if (adv) begin
      v[0] <= in_valid;
      bw[0] <= 1'b0;
      s[0] <= in_sum;
      a[0] <= in_a;
      d[0] <= '0;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        bw[i] <= bo[i-1];
        s[i] <= s[i-1] >> SW;
        a[i] <= a[i-1] >> SW;
        d[i] <= (d[i-1] >> SW) | (WIDTH'(diff[i-1]) << (WIDTH - SW));
      end
      out_valid <= v[L];
      out_b <= (d[L] >> SW) | (WIDTH'(diff[L]) << (WIDTH - SW));
      flags <= '{under: ~top & bo[L], ovf: top & ~bo[L]};
    end
endmodule

// File: doc/cla32_sub_pipe.md
Name: cla32_sub_pipe

Overview:
- Inverse of the 32-bit carry-lookahead adder: given a 33-bit sum S and one addend A, recovers the other addend B = S − A.
- Flags results that do not fit in 32 bits.
- Pipelined as a borrow-ripple subtractor: one slice of WIDTH/STAGES bits per stage, valid/ready handshake on both sides.
- Used as the self-check/decode path beside the adder, and as a streaming subtract unit for the datapath.

Parameters:
- WIDTH, 32, addend width; the sum input is WIDTH+1 bits.
- STAGES, 4, pipeline depth; WIDTH must be divisible by STAGES. Slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept operands this cycle.
- in_sum  input  WIDTH+1  minuend S.
- in_a  input  WIDTH  subtrahend A.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_b  output  WIDTH  low WIDTH bits of S − A.
- out_under  output  1  S < A (true result is negative).
- out_ovf  output  1  S − A ≥ 2^WIDTH (B does not fit).

Behaviour:
- Reset (async, active-high): all stage valid bits clear; out_valid=0, out_b=0, out_under=0, out_ovf=0. in_ready=1 once rst deasserts.
- Arithmetic: D = {1'b0,S} − {2'b0,A}, computed at WIDTH+2 bits.
  - out_b = D[WIDTH-1:0]
  - out_under = D[WIDTH+1]
  - out_ovf = D[WIDTH] & ~D[WIDTH+1]
  - When out_under=1, out_b is the two's-complement wrap value.
- Pipeline structure:
  - Stage k (0..STAGES-1) subtracts slice k (bits k*SW+SW-1 : k*SW) of S and A, using the borrow registered by stage k−1. Stage 0 borrow-in = 0.
  - Unprocessed upper operand slices are carried forward (input skew).
  - Completed lower result slices are carried forward (output deskew).
  - The last stage additionally resolves S[WIDTH] and the final borrow into out_ovf and out_under.
- Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv. No combinational path from in_valid to in_ready.
  - When adv=1, every stage register loads from its predecessor, and stage 0 loads {in_valid, operands}.
  - When adv=0, all stages hold, including data.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1, assuming no backpressure.
- Throughput: one result per cycle under continuous in_valid=1 and out_ready=1.
- Handshake rules:
  - A transfer occurs on an edge where valid & ready.
  - While out_valid=1 and out_ready=0, out_b/out_under/out_ovf stay stable.
  - in_ready=0 in that condition, so no input is accepted.
  - Bubbles (invalid stages) advance normally and are removed when the pipeline fills.
- Ordering: results emerge in acceptance order; nothing is dropped or duplicated.
- Reset mid-operation: all in-flight results are discarded. out_valid drops asynchronously, and no stale result appears after rst deasserts.
- Data registers of invalid stages are don't-care, except that the output data registers are 0 after reset.

Decomposition:
- Package cla_pkg:
  - constants CLA_WIDTH=32, CLA_STAGES=4
  - derived SLICE_W
  - result-flag struct/typedef {under, ovf}
- Sub-module sub_slice: combinational SW-bit subtract with borrow-in/borrow-out. Instantiated once per stage via generate.
- The stage/shift registers live in the top module.

Test Plan:
- Basic: S=0x0_0000_0004, A=2 → out_b=0x0000_0002, under=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Carry inverse: S=0x1_FFFF_FFFE, A=0xFFFF_FFFF → out_b=0xFFFF_FFFF, under=0, ovf=0. Also S=0x1_0000_0000, A=0 → out_b=0, ovf=1, under=0.
- Underflow: S=5, A=6 → out_b=0xFFFF_FFFF, under=1, ovf=0.
- Borrow across every slice: S=0x0_0100_0000, A=1 → out_b=0x00FF_FFFF, flags 0.
- Streaming plus backpressure: 10 back-to-back random pairs, each S = A+B computed with the adder. Hold out_ready=0 for 3 cycles mid-stream → in_ready=0, outputs stable, all 10 B values returned in order, no loss or duplication.
- Reset mid-flight: accept 3 operands, assert rst for 1 cycle at cycle 2 → out_valid=0 immediately. After release, no result appears until a new operand is accepted; that operand then returns after 4 cycles.
